// File: rtl/cu_pkg.sv
// Shared definitions for the fetch buffer and the compute unit.
// Instruction layout: OPC[15:12] TGT[11:8] SRC0[7:4] SRC1[3:0].
package cu_pkg;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned BYTE_W  = 8;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LOAD = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_NOT  = 4'h6;
   localparam logic [3:0] OP_XOR  = 4'h7;

   localparam int unsigned OPC_MSB  = 15;
   localparam int unsigned OPC_LSB  = 12;
   localparam int unsigned TGT_MSB  = 11;
   localparam int unsigned TGT_LSB  = 8;
   localparam int unsigned SRC0_MSB = 7;
   localparam int unsigned SRC0_LSB = 4;
   localparam int unsigned SRC1_MSB = 3;
   localparam int unsigned SRC1_LSB = 0;

   typedef enum logic {
      PH_HI = 1'b0,
      PH_LO = 1'b1
   } phase_e;

   function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/instr_fetch_buffer_if.sv
// Host byte stream in, issued instruction stream out.
interface instr_fetch_buffer_if #(
   parameter int unsigned DEPTH = 4
);
   import cu_pkg::*;

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [BYTE_W-1:0]  byte_in;
   logic               byte_valid;
   logic               byte_ready;
   logic               flush;
   logic               issue_hold;
   logic [INSTR_W-1:0] instruction;
   logic               en;
   logic [CNT_W-1:0]   fifo_count;
   logic               phase_lo;

   modport master (
      output byte_in, byte_valid, flush, issue_hold,
      input  byte_ready, instruction, en, fifo_count, phase_lo
   );

   modport slave (
      input  byte_in, byte_valid, flush, issue_hold,
      output byte_ready, instruction, en, fifo_count, phase_lo
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count and combinational head/full/empty.
module sync_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_clr,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [WIDTH-1:0]           i_data,
   output logic [WIDTH-1:0]           o_head_c,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_full_c,
   output logic                       o_empty_c
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full_c  = (r_count == CNT_W'(DEPTH));
   assign o_empty_c = (r_count == '0);
   assign o_head_c  = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   assign w_push = i_push & ~o_full_c;
   assign w_pop  = i_pop & ~o_empty_c;

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !i_clr) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Packs host bytes (high first) into 16-bit instructions, buffers them and
// issues at most one per cycle with a single-cycle en strobe.
module instr_fetch_buffer
   import cu_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter bit          DROP_NOP = 1'b0
) (
   input  logic                 clk,
   input  logic                 rstn,
   instr_fetch_buffer_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   phase_e             r_state;
   phase_e             w_state_nxt;
   logic [BYTE_W-1:0]  r_hi;
   logic [INSTR_W-1:0] r_instr;
   logic               r_en;

   logic               w_hi_load;
   logic               w_push;
   logic               w_pop;
   logic               w_xfer;
   logic               w_drop;
   logic               w_full;
   logic               w_empty;
   logic [INSTR_W-1:0] w_word;
   logic [INSTR_W-1:0] w_head;
   logic [CNT_W-1:0]   w_count;

   // Ready depends only on registered occupancy, so a same-edge pop never gates a push.
   assign w_xfer = bus.byte_valid & ~w_full;
   assign w_word = {r_hi, bus.byte_in};
   assign w_drop = DROP_NOP && (opcode_of(w_word) == OP_NOP);
   assign w_pop  = ~bus.flush & ~bus.issue_hold & ~w_empty;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= PH_HI;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_hi_load   = 1'b0;
      w_push      = 1'b0;
      if (bus.flush) begin
         w_state_nxt = PH_HI;
      end else begin
         case (r_state)
            PH_HI: begin
               if (w_xfer) begin
                  w_hi_load   = 1'b1;
                  w_state_nxt = PH_LO;
               end
            end
            PH_LO: begin
               if (w_xfer) begin
                  w_push      = ~w_drop;
                  w_state_nxt = PH_HI;
               end
            end
            default: w_state_nxt = PH_HI;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)          r_hi <= '0;
      else if (bus.flush) r_hi <= '0;
      else if (w_hi_load) r_hi <= bus.byte_in;
   end

   // Issue stage; instruction holds across idle and flush cycles.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_en    <= 1'b0;
         r_instr <= '0;
      end else begin
         r_en <= w_pop;
         if (w_pop) r_instr <= w_head;
      end
   end

   sync_fifo #(
      .WIDTH (INSTR_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rstn),
      .i_clr     (bus.flush),
      .i_push    (w_push),
      .i_pop     (w_pop),
      .i_data    (w_word),
      .o_head_c  (w_head),
      .o_count   (w_count),
      .o_full_c  (w_full),
      .o_empty_c (w_empty)
   );

   assign bus.byte_ready  = ~w_full;
   assign bus.instruction = r_instr;
   assign bus.en          = r_en;
   assign bus.fifo_count  = w_count;
   assign bus.phase_lo    = (r_state == PH_LO);

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: directed scenarios plus random traffic against a queue model.
module tb_instr_fetch_buffer;
   import cu_pkg::*;

   localparam int DEPTH = 4;

   logic       clk     = 1'b0;
   logic       rstn    = 1'b0;
   logic [7:0] b_in    = 8'h00;
   logic       b_valid = 1'b0;
   logic       flush   = 1'b0;
   logic       hold    = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   instr_fetch_buffer_if #(.DEPTH(DEPTH)) bus_a ();
   instr_fetch_buffer_if #(.DEPTH(DEPTH)) bus_b ();

   assign bus_a.byte_in    = b_in;
   assign bus_a.byte_valid = b_valid;
   assign bus_a.flush      = flush;
   assign bus_a.issue_hold = hold;
   assign bus_b.byte_in    = b_in;
   assign bus_b.byte_valid = b_valid;
   assign bus_b.flush      = flush;
   assign bus_b.issue_hold = hold;

   instr_fetch_buffer #(.DEPTH(DEPTH), .DROP_NOP(1'b0)) dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
   instr_fetch_buffer #(.DEPTH(DEPTH), .DROP_NOP(1'b1)) dut_b (.clk(clk), .rstn(rstn), .bus(bus_b));

   always #5 clk = ~clk;

   // Reference model of dut_a: a queue of instructions plus the pending high byte.
   logic [15:0] m_q[$];
   logic        m_ph    = 1'b0;
   logic [7:0]  m_hi    = 8'h00;
   logic        m_en    = 1'b0;
   logic [15:0] m_instr = 16'h0000;

   always @(posedge clk or negedge rstn) begin : model
      bit xfer;
      if (!rstn) begin
         m_q.delete();
         m_ph    = 1'b0;
         m_hi    = 8'h00;
         m_en    = 1'b0;
         m_instr = 16'h0000;
      end else begin
         xfer = b_valid && (m_q.size() < DEPTH);
         if (flush) begin
            m_q.delete();
            m_ph = 1'b0;
            m_hi = 8'h00;
            m_en = 1'b0;
         end else begin
            if (!hold && m_q.size() > 0) begin
               m_instr = m_q.pop_front();
               m_en    = 1'b1;
            end else begin
               m_en = 1'b0;
            end
            if (xfer) begin
               if (!m_ph) begin
                  m_hi = b_in;
                  m_ph = 1'b1;
               end else begin
                  m_q.push_back({m_hi, b_in});
                  m_ph = 1'b0;
               end
            end
         end
      end
   end

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++; if (bus_a.en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", bus_a.en); end
      n_tests++; if (bus_a.instruction !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h want 0000", bus_a.instruction); end
      n_tests++; if (bus_a.fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus_a.fifo_count); end
      n_tests++; if (bus_a.phase_lo !== 1'b0) begin n_fail++; $display("FAIL reset_phase: got %b want 0", bus_a.phase_lo); end
      n_tests++; if (bus_a.byte_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus_a.byte_ready); end
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      hold = 1'b0; b_valid = 1'b1; b_in = 8'h13;
      @(negedge clk);
      n_tests++; if (bus_a.phase_lo !== 1'b1) begin n_fail++; $display("FAIL basic_phase: got %b want 1", bus_a.phase_lo); end
      b_in = 8'h2A;
      @(negedge clk);
      b_valid = 1'b0;
      n_tests++; if (bus_a.en !== 1'b0) begin n_fail++; $display("FAIL basic_no_bypass: got en=%b want 0", bus_a.en); end
      n_tests++; if (bus_a.fifo_count !== 3'd1) begin n_fail++; $display("FAIL basic_count1: got %0d want 1", bus_a.fifo_count); end
      @(negedge clk);
      n_tests++; if (bus_a.en !== 1'b1) begin n_fail++; $display("FAIL basic_en: got %b want 1", bus_a.en); end
      n_tests++; if (bus_a.instruction !== 16'h132A) begin n_fail++; $display("FAIL basic_instr: got %h want 132a", bus_a.instruction); end
      n_tests++; if (bus_a.fifo_count !== 3'd0) begin n_fail++; $display("FAIL basic_count0: got %0d want 0", bus_a.fifo_count); end
      @(negedge clk);
      n_tests++; if (bus_a.en !== 1'b0) begin n_fail++; $display("FAIL basic_en_once: got %b want 0", bus_a.en); end
   endtask

   task automatic test_backpressure();
      int pulses;
      int sent;
      logic acc;
      hold = 1'b1; b_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b_in = (i % 2 == 0) ? 8'h21 : 8'h01;
         @(negedge clk);
      end
      n_tests++; if (bus_a.fifo_count !== 3'd4) begin n_fail++; $display("FAIL bp_full_count: got %0d want 4", bus_a.fifo_count); end
      n_tests++; if (bus_a.byte_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b want 0", bus_a.byte_ready); end
      b_in = 8'h21;
      repeat (3) @(negedge clk);
      n_tests++; if (bus_a.phase_lo !== 1'b0) begin n_fail++; $display("FAIL bp_byte9_stalled: got phase %b want 0", bus_a.phase_lo); end
      n_tests++; if (bus_a.fifo_count !== 3'd4) begin n_fail++; $display("FAIL bp_stall_count: got %0d want 4", bus_a.fifo_count); end
      hold = 1'b0;
      pulses = 0; sent = 8;
      for (int c = 0; c < 10; c++) begin
         acc = b_valid && bus_a.byte_ready;
         @(negedge clk);
         if (acc) begin
            sent++;
            if (sent == 9) b_in = 8'h01;
            else b_valid = 1'b0;
         end
         if (bus_a.en === 1'b1) begin
            pulses++;
            n_tests++; if (bus_a.instruction !== 16'h2101) begin n_fail++; $display("FAIL bp_instr: got %h want 2101", bus_a.instruction); end
         end
         n_tests++; if (bus_a.en !== m_en) begin n_fail++; $display("FAIL bp_en_model c%0d: got %b want %b", c, bus_a.en, m_en); end
      end
      b_valid = 1'b0;
      n_tests++; if (pulses !== 5) begin n_fail++; $display("FAIL bp_pulses: got %0d want 5", pulses); end
      n_tests++; if (sent !== 10) begin n_fail++; $display("FAIL bp_bytes_accepted: got %0d want 10", sent); end
   endtask

   task automatic test_simultaneous();
      logic [7:0] seq [5];
      seq = '{8'h23, 8'h45, 8'h34, 8'h56, 8'h45};
      hold = 1'b1; b_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         b_in = seq[i];
         @(negedge clk);
      end
      n_tests++; if (bus_a.fifo_count !== 3'd2) begin n_fail++; $display("FAIL sim_pre_count: got %0d want 2", bus_a.fifo_count); end
      hold = 1'b0; b_in = 8'h67;
      @(negedge clk);
      b_valid = 1'b0;
      n_tests++; if (bus_a.fifo_count !== 3'd2) begin n_fail++; $display("FAIL sim_count: got %0d want 2", bus_a.fifo_count); end
      n_tests++; if (bus_a.instruction !== 16'h2345 || bus_a.en !== 1'b1) begin n_fail++; $display("FAIL sim_first: got %h/%b want 2345/1", bus_a.instruction, bus_a.en); end
      @(negedge clk);
      n_tests++; if (bus_a.instruction !== 16'h3456 || bus_a.en !== 1'b1) begin n_fail++; $display("FAIL sim_second: got %h/%b want 3456/1", bus_a.instruction, bus_a.en); end
      @(negedge clk);
      n_tests++; if (bus_a.instruction !== 16'h4567 || bus_a.en !== 1'b1) begin n_fail++; $display("FAIL sim_third: got %h/%b want 4567/1", bus_a.instruction, bus_a.en); end
      n_tests++; if (bus_a.fifo_count !== 3'd0) begin n_fail++; $display("FAIL sim_drain: got %0d want 0", bus_a.fifo_count); end
   endtask

   task automatic test_flush_reset();
      hold = 1'b0; b_valid = 1'b1; b_in = 8'h34;
      @(negedge clk);
      n_tests++; if (bus_a.phase_lo !== 1'b1) begin n_fail++; $display("FAIL fl_phase_pre: got %b want 1", bus_a.phase_lo); end
      flush = 1'b1; b_in = 8'h99;
      @(negedge clk);
      flush = 1'b0; b_valid = 1'b0;
      n_tests++; if (bus_a.phase_lo !== 1'b0) begin n_fail++; $display("FAIL fl_phase: got %b want 0", bus_a.phase_lo); end
      n_tests++; if (bus_a.fifo_count !== 3'd0) begin n_fail++; $display("FAIL fl_count: got %0d want 0", bus_a.fifo_count); end
      n_tests++; if (bus_a.instruction !== 16'h4567) begin n_fail++; $display("FAIL fl_instr_hold: got %h want 4567", bus_a.instruction); end
      b_valid = 1'b1; b_in = 8'h41;
      @(negedge clk);
      b_in = 8'h12;
      @(negedge clk);
      b_valid = 1'b0;
      @(negedge clk);
      n_tests++; if (bus_a.en !== 1'b1 || bus_a.instruction !== 16'h4112) begin n_fail++; $display("FAIL fl_after: got %h/%b want 4112/1", bus_a.instruction, bus_a.en); end
      hold = 1'b1; b_valid = 1'b1;
      b_in = 8'h41; @(negedge clk);
      b_in = 8'h12; @(negedge clk);
      b_in = 8'h34; @(negedge clk);
      b_valid = 1'b0;
      n_tests++; if (bus_a.fifo_count !== 3'd1 || bus_a.phase_lo !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got count %0d phase %b want 1 1", bus_a.fifo_count, bus_a.phase_lo); end
      #2 rstn = 1'b0;
      #1;
      n_tests++; if (bus_a.instruction !== 16'h0000) begin n_fail++; $display("FAIL arst_instr: got %h want 0000", bus_a.instruction); end
      n_tests++; if (bus_a.fifo_count !== 3'd0) begin n_fail++; $display("FAIL arst_count: got %0d want 0", bus_a.fifo_count); end
      n_tests++; if (bus_a.phase_lo !== 1'b0) begin n_fail++; $display("FAIL arst_phase: got %b want 0", bus_a.phase_lo); end
      n_tests++; if (bus_a.en !== 1'b0) begin n_fail++; $display("FAIL arst_en: got %b want 0", bus_a.en); end
      @(negedge clk);
      rstn = 1'b1; hold = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_hold_timing();
      logic [7:0] seq [6];
      seq = '{8'h5A, 8'h01, 8'h6B, 8'h02, 8'h7C, 8'h03};
      hold = 1'b1; b_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         b_in = seq[i];
         @(negedge clk);
      end
      b_valid = 1'b0;
      n_tests++; if (bus_a.fifo_count !== 3'd3) begin n_fail++; $display("FAIL hold_pre_count: got %0d want 3", bus_a.fifo_count); end
      hold = 1'b0;
      @(negedge clk);
      hold = 1'b1;
      n_tests++; if (bus_a.en !== 1'b1 || bus_a.instruction !== 16'h5A01) begin n_fail++; $display("FAIL hold_first: got %h/%b want 5a01/1", bus_a.instruction, bus_a.en); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_tests++; if (bus_a.en !== 1'b0 || bus_a.fifo_count !== 3'd2) begin n_fail++; $display("FAIL hold_blocked c%0d: got en %b count %0d want 0 2", c, bus_a.en, bus_a.fifo_count); end
      end
      hold = 1'b0;
      @(negedge clk);
      n_tests++; if (bus_a.en !== 1'b1 || bus_a.instruction !== 16'h6B02) begin n_fail++; $display("FAIL hold_second: got %h/%b want 6b02/1", bus_a.instruction, bus_a.en); end
      @(negedge clk);
      n_tests++; if (bus_a.en !== 1'b1 || bus_a.instruction !== 16'h7C03) begin n_fail++; $display("FAIL hold_third: got %h/%b want 7c03/1", bus_a.instruction, bus_a.en); end
   endtask

   task automatic test_drop_nop();
      logic [7:0]  seq [4];
      logic [15:0] a_iss[$];
      logic [15:0] b_iss[$];
      int          b_max;
      seq = '{8'h00, 8'h55, 8'h71, 8'h23};
      b_max = 0;
      flush = 1'b1; @(negedge clk); flush = 1'b0;
      hold = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (c < 4) begin b_valid = 1'b1; b_in = seq[c]; end
         else b_valid = 1'b0;
         @(negedge clk);
         if (bus_a.en === 1'b1) a_iss.push_back(bus_a.instruction);
         if (bus_b.en === 1'b1) b_iss.push_back(bus_b.instruction);
         if (int'(bus_b.fifo_count) > b_max) b_max = int'(bus_b.fifo_count);
      end
      n_tests++; if (b_iss.size() !== 1) begin n_fail++; $display("FAIL drop_b_count: got %0d issues want 1", b_iss.size()); end
      else begin
         n_tests++; if (b_iss[0] !== 16'h7123) begin n_fail++; $display("FAIL drop_b_instr: got %h want 7123", b_iss[0]); end
      end
      n_tests++; if (b_max > 1) begin n_fail++; $display("FAIL drop_b_max: got %0d want <=1", b_max); end
      n_tests++; if (a_iss.size() !== 2) begin n_fail++; $display("FAIL nodrop_a_count: got %0d issues want 2", a_iss.size()); end
      else begin
         n_tests++; if (a_iss[0] !== 16'h0055 || a_iss[1] !== 16'h7123) begin n_fail++; $display("FAIL nodrop_a_order: got %h %h want 0055 7123", a_iss[0], a_iss[1]); end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         n_tests++; if (bus_a.en !== m_en) begin n_fail++; $display("FAIL rnd_en c%0d: got %b want %b", c, bus_a.en, m_en); end
         n_tests++; if (bus_a.instruction !== m_instr) begin n_fail++; $display("FAIL rnd_instr c%0d: got %h want %h", c, bus_a.instruction, m_instr); end
         n_tests++; if (bus_a.fifo_count !== 3'(m_q.size())) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, bus_a.fifo_count, m_q.size()); end
         n_tests++; if (bus_a.phase_lo !== m_ph) begin n_fail++; $display("FAIL rnd_phase c%0d: got %b want %b", c, bus_a.phase_lo, m_ph); end
         n_tests++; if (bus_a.byte_ready !== (m_q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, bus_a.byte_ready, (m_q.size() < DEPTH)); end
         b_valid = ($urandom_range(0, 9) < 7);
         b_in    = 8'($urandom);
         if ($urandom_range(0, 9) == 0) hold = ~hold;
         flush   = ($urandom_range(0, 99) < 3);
      end
      b_valid = 1'b0; flush = 1'b0; hold = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_simultaneous();
      test_flush_reset();
      test_hold_timing();
      test_drop_nop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
